// File: rtl/ad_serdes_pkg.sv
// Shared types and helpers for the LVDS receive word aligner.
// Lane state encoding, counter sizing and the default training word.
package ad_serdes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_CHECK  = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4
    } lane_state_e;

    localparam logic [7:0] DEFAULT_TRAIN_PATTERN = 8'hB8;

    // Bits needed to hold values 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        if (max_val < 2) begin
            return 1;
        end else begin
            return $clog2(max_val + 1);
        end
    endfunction

endpackage

// File: rtl/ad_serdes_in_lane_align.sv
// One receive lane: previous-word register, barrel select, alignment FSM and counters.
// With AD_SERDES_IN_ALIGN_ERRCNT_EN defined, also counts mismatching words while locked.
module ad_serdes_in_lane_align
    import ad_serdes_pkg::*;
#(
    parameter int                       SERDES_FACTOR = 8,
    parameter logic [SERDES_FACTOR-1:0] TRAIN_PATTERN = SERDES_FACTOR'(DEFAULT_TRAIN_PATTERN),
    parameter int                       MATCH_COUNT   = 16
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_align_req,
    input  logic                     i_in_valid,
    input  logic [SERDES_FACTOR-1:0] i_data,
`ifdef AD_SERDES_IN_ALIGN_ERRCNT_EN
    input  logic                     i_check_en,
    output logic [15:0]              o_err_cnt,
`endif
    output logic [SERDES_FACTOR-1:0] o_data,
    output logic                     o_locked,
    output lane_state_e              o_state
);

    localparam int OFS_W = cnt_width(SERDES_FACTOR - 1);
    localparam int MC_W  = cnt_width(MATCH_COUNT);
    localparam int SC_W  = cnt_width(2 * SERDES_FACTOR);
    localparam logic [OFS_W-1:0] OFS_LAST = OFS_W'(SERDES_FACTOR - 1);
    localparam logic [MC_W-1:0]  MC_LOCK  = MC_W'(MATCH_COUNT);
    localparam logic [SC_W-1:0]  SC_FAIL  = SC_W'(2 * SERDES_FACTOR);

    lane_state_e                r_state, w_state_nxt;
    logic [OFS_W-1:0]           r_offset, w_offset_nxt, w_ofs_inc;
    logic [MC_W-1:0]            r_match_cnt, w_match_nxt;
    logic [SC_W-1:0]            r_slip_cnt, w_slip_nxt, w_slip_inc;
    logic [SERDES_FACTOR-1:0]   r_prev, r_word, w_sel;
    logic [2*SERDES_FACTOR-1:0] w_cat_sh;
    logic                       r_locked, w_locked_nxt, w_hit;

    // Offset k picks {cur[k-1:0], prev[SF-1:k]}: the older word sits in the low half.
    assign w_cat_sh   = {i_data, r_prev} >> r_offset;
    assign w_sel      = w_cat_sh[SERDES_FACTOR-1:0];
    assign w_hit      = (w_sel == TRAIN_PATTERN);
    assign w_slip_inc = r_slip_cnt + SC_W'(1);
    assign w_ofs_inc  = (r_offset == OFS_LAST) ? {OFS_W{1'b0}} : r_offset + OFS_W'(1);

    // Lane state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus offset/counter updates; align_req beats any arriving word.
    always_comb begin
        w_state_nxt  = r_state;
        w_offset_nxt = r_offset;
        w_match_nxt  = r_match_cnt;
        w_slip_nxt   = r_slip_cnt;
        if (i_align_req) begin
            w_state_nxt  = ST_SEARCH;
            w_offset_nxt = {OFS_W{1'b0}};
            w_match_nxt  = {MC_W{1'b0}};
            w_slip_nxt   = {SC_W{1'b0}};
        end else if (i_in_valid) begin
            case (r_state)
                ST_SEARCH, ST_CHECK: begin
                    if (w_hit) begin
                        w_match_nxt = (r_state == ST_SEARCH) ? MC_W'(1) : r_match_cnt + MC_W'(1);
                        w_state_nxt = (w_match_nxt == MC_LOCK) ? ST_LOCKED : ST_CHECK;
                    end else begin
                        w_match_nxt = {MC_W{1'b0}};
                        w_slip_nxt  = w_slip_inc;
                        if (w_slip_inc == SC_FAIL) begin
                            w_state_nxt = ST_FAIL;
                        end else begin
                            w_state_nxt  = ST_SEARCH;
                            w_offset_nxt = w_ofs_inc;
                        end
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Lock flag follows the state it will enter, so it registers alongside the state.
    always_comb begin
        w_locked_nxt = (w_state_nxt == ST_LOCKED);
    end

    // Datapath registers: counters, offset, previous word and aligned output word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_offset    <= {OFS_W{1'b0}};
            r_match_cnt <= {MC_W{1'b0}};
            r_slip_cnt  <= {SC_W{1'b0}};
            r_prev      <= {SERDES_FACTOR{1'b0}};
            r_word      <= {SERDES_FACTOR{1'b0}};
            r_locked    <= 1'b0;
        end else begin
            r_offset    <= w_offset_nxt;
            r_match_cnt <= w_match_nxt;
            r_slip_cnt  <= w_slip_nxt;
            r_locked    <= w_locked_nxt;
            if (i_in_valid) begin
                r_prev <= i_data;
                r_word <= w_sel;
            end else begin
                r_prev <= r_prev;
                r_word <= r_word;
            end
        end
    end

`ifdef AD_SERDES_IN_ALIGN_ERRCNT_EN
    logic [15:0] r_err_cnt;

    // Saturating count of bad aligned words seen while locked and checking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt <= 16'h0000;
        end else if (i_align_req) begin
            r_err_cnt <= 16'h0000;
        end else if (i_in_valid && i_check_en && (r_state == ST_LOCKED) && !w_hit
                     && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end else begin
            r_err_cnt <= r_err_cnt;
        end
    end

    assign o_err_cnt = r_err_cnt;
`endif

    assign o_data   = r_word;
    assign o_locked = r_locked;
    assign o_state  = r_state;

endmodule

// File: rtl/ad_serdes_in_align.sv
// Receive word aligner: one lane aligner per SERDES lane plus link-wide done/fail status.
// Optional per-lane error counters are enabled with AD_SERDES_IN_ALIGN_ERRCNT_EN.
module ad_serdes_in_align
    import ad_serdes_pkg::*;
#(
    parameter int                       SERDES_FACTOR = 8,
    parameter int                       DATA_WIDTH    = 16,
    parameter logic [SERDES_FACTOR-1:0] TRAIN_PATTERN = SERDES_FACTOR'(DEFAULT_TRAIN_PATTERN),
    parameter int                       MATCH_COUNT   = 16
)(
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  align_req,
    input  logic                                  in_valid,
    input  logic [DATA_WIDTH*SERDES_FACTOR-1:0]   data_in,
`ifdef AD_SERDES_IN_ALIGN_ERRCNT_EN
    input  logic                                  check_en,
    output logic [DATA_WIDTH*16-1:0]              err_cnt,
`endif
    output logic                                  out_valid,
    output logic [DATA_WIDTH*SERDES_FACTOR-1:0]   data_out,
    output logic [DATA_WIDTH-1:0]                 locked,
    output logic                                  align_done,
    output logic                                  align_fail
);

    lane_state_e w_state [DATA_WIDTH];
    logic        w_all_end, w_any_fail;
    logic        r_out_valid, r_align_done, r_align_fail;

    genvar g;
    generate
        for (g = 0; g < DATA_WIDTH; g++) begin : g_lane
            ad_serdes_in_lane_align #(
                .SERDES_FACTOR (SERDES_FACTOR),
                .TRAIN_PATTERN (TRAIN_PATTERN),
                .MATCH_COUNT   (MATCH_COUNT)
            ) u_lane (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_align_req (align_req),
                .i_in_valid  (in_valid),
                .i_data      (data_in[g*SERDES_FACTOR +: SERDES_FACTOR]),
`ifdef AD_SERDES_IN_ALIGN_ERRCNT_EN
                .i_check_en  (check_en),
                .o_err_cnt   (err_cnt[g*16 +: 16]),
`endif
                .o_data      (data_out[g*SERDES_FACTOR +: SERDES_FACTOR]),
                .o_locked    (locked[g]),
                .o_state     (w_state[g])
            );
        end
    endgenerate

    // Link is finished only when no lane is still idle or hunting.
    always_comb begin
        w_all_end  = 1'b1;
        w_any_fail = 1'b0;
        for (int l = 0; l < DATA_WIDTH; l++) begin
            w_all_end  = w_all_end & ((w_state[l] == ST_LOCKED) | (w_state[l] == ST_FAIL));
            w_any_fail = w_any_fail | (w_state[l] == ST_FAIL);
        end
    end

    // Registered qualifier and link status.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_align_done <= 1'b0;
            r_align_fail <= 1'b0;
        end else begin
            r_out_valid  <= in_valid;
            r_align_done <= w_all_end;
            r_align_fail <= w_all_end & w_any_fail;
        end
    end

    assign out_valid  = r_out_valid;
    assign align_done = r_align_done;
    assign align_fail = r_align_fail;

endmodule

// File: tb/tb_ad_serdes_in_align.sv
// Self-checking bench for ad_serdes_in_align: behavioural lane model compared every cycle
// plus hand-computed checkpoints for each directed scenario.
module tb_ad_serdes_in_align;

    localparam int         SF  = 8;
    localparam int         DW  = 16;
    localparam int         MC  = 16;
    localparam logic [7:0] PAT = 8'hB8;

    logic             clk = 1'b0;
    logic             rst_n, align_req, in_valid;
    logic [DW*SF-1:0] data_in, data_out;
    logic             out_valid, align_done, align_fail;
    logic [DW-1:0]    locked;
`ifdef AD_SERDES_IN_ALIGN_ERRCNT_EN
    logic             check_en;
    logic [DW*16-1:0] err_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] lane_data [DW];

    int         m_st [DW];   // 0 idle, 1 search, 2 check, 3 locked, 4 fail
    int         m_ofs [DW], m_mc [DW], m_sc [DW], m_err [DW];
    logic [7:0] m_prev [DW], m_dout [DW];
    logic       m_valid, m_done, m_fail;
    logic [DW-1:0] m_locked;
    bit         live = 1'b0;

    ad_serdes_in_align dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .align_req  (align_req),
        .in_valid   (in_valid),
        .data_in    (data_in),
`ifdef AD_SERDES_IN_ALIGN_ERRCNT_EN
        .check_en   (check_en),
        .err_cnt    (err_cnt),
`endif
        .out_valid  (out_valid),
        .data_out   (data_out),
        .locked     (locked),
        .align_done (align_done),
        .align_fail (align_fail)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sel_word(input logic [7:0] p, input logic [7:0] c, input int k);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = (j + k < 8) ? p[j + k] : c[j + k - 8];
        return r;
    endfunction

    function automatic logic [7:0] rol(input logic [7:0] w, input int n);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[(j + n) % 8] = w[j];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic model_step();
        bit all_end, any_fail, hit;
        logic [7:0] cur, sel;
        if (!rst_n) begin
            for (int l = 0; l < DW; l++) begin
                m_st[l] = 0; m_ofs[l] = 0; m_mc[l] = 0; m_sc[l] = 0; m_err[l] = 0;
                m_prev[l] = 8'h00; m_dout[l] = 8'h00;
            end
            m_valid = 1'b0; m_done = 1'b0; m_fail = 1'b0;
        end else begin
            all_end = 1'b1; any_fail = 1'b0;
            for (int l = 0; l < DW; l++) begin
                if (m_st[l] < 3) all_end = 1'b0;
                if (m_st[l] == 4) any_fail = 1'b1;
            end
            m_done  = all_end;
            m_fail  = all_end && any_fail;
            m_valid = in_valid;
            for (int l = 0; l < DW; l++) begin
                cur = data_in[l*SF +: SF];
                sel = sel_word(m_prev[l], cur, m_ofs[l]);
                hit = (sel == PAT);
                if (in_valid) m_dout[l] = sel;
`ifdef AD_SERDES_IN_ALIGN_ERRCNT_EN
                if (align_req) m_err[l] = 0;
                else if (in_valid && check_en && m_st[l] == 3 && !hit && m_err[l] < 65535) m_err[l]++;
`endif
                if (align_req) begin
                    m_st[l] = 1; m_ofs[l] = 0; m_mc[l] = 0; m_sc[l] = 0;
                end else if (in_valid && (m_st[l] == 1 || m_st[l] == 2)) begin
                    if (hit) begin
                        m_mc[l] = (m_st[l] == 1) ? 1 : m_mc[l] + 1;
                        m_st[l] = (m_mc[l] >= MC) ? 3 : 2;
                    end else begin
                        m_mc[l] = 0;
                        m_sc[l]++;
                        if (m_sc[l] >= 2 * SF) m_st[l] = 4;
                        else begin m_ofs[l] = (m_ofs[l] + 1) % SF; m_st[l] = 1; end
                    end
                end
                if (in_valid) m_prev[l] = cur;
            end
        end
        for (int l = 0; l < DW; l++) m_locked[l] = (m_st[l] == 3);
        live = 1'b1;
    endtask

    task automatic cyc(input bit ar, input bit v, input bit rn);
        rst_n = rn; align_req = ar; in_valid = v;
        for (int l = 0; l < DW; l++) data_in[l*SF +: SF] = v ? lane_data[l] : 8'h5A;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1);
    endtask

    task automatic set_all(input logic [7:0] w);
        for (int l = 0; l < DW; l++) lane_data[l] = w;
    endtask

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (live) begin
                chk("out_valid", out_valid, m_valid);
                chk("locked", locked, m_locked);
                chk("align_done", align_done, m_done);
                chk("align_fail", align_fail, m_fail);
                if (m_valid)
                    for (int l = 0; l < DW; l++)
                        chk($sformatf("data_out[%0d]", l), data_out[l*SF +: SF], m_dout[l]);
`ifdef AD_SERDES_IN_ALIGN_ERRCNT_EN
                for (int l = 0; l < DW; l++)
                    chk($sformatf("err_cnt[%0d]", l), err_cnt[l*16 +: 16], 16'(m_err[l]));
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; align_req = 1'b0; in_valid = 1'b0; data_in = '0;
`ifdef AD_SERDES_IN_ALIGN_ERRCNT_EN
        check_en = 1'b0;
`endif
        set_all(PAT);
        chk("model_rot3", sel_word(rol(PAT, 3), rol(PAT, 3), 3), 8'hB8);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("rst_locked", locked, 16'h0000);
        chk("rst_done", align_done, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);

        // Lane 0 rotated by 3; other lanes already aligned.
        lane_data[0] = 8'hC5;
        cyc(1'b1, 1'b1, 1'b1);
        run(18); chk("s1_prelock", locked[0], 1'b0);
        run(1);  chk("s1_lock", locked[0], 1'b1);
        chk("s1_data", data_out[7:0], 8'hB8);
        run(1);  chk("s1_done", align_done, 1'b1); chk("s1_fail", align_fail, 1'b0);

        // Lanes 0..7 rotated by 0..7.
        set_all(PAT);
        for (int l = 0; l < 8; l++) lane_data[l] = rol(PAT, l);
        cyc(1'b1, 1'b1, 1'b1);
        chk("s2_restart", locked, 16'h0000);
        run(22); chk("s2_partial", locked, 16'hFF7F);
        run(1);  chk("s2_all", locked, 16'hFFFF); chk("s2_done_lag", align_done, 1'b0);
        run(1);  chk("s2_done", align_done, 1'b1); chk("s2_fail", align_fail, 1'b0);

        // Lane 5 stuck at zero.
        set_all(PAT); lane_data[5] = 8'h00;
        cyc(1'b1, 1'b1, 1'b1);
        run(15); chk("s3_pre", locked, 16'h0000);
        run(1);  chk("s3_locked", locked, 16'hFFDF);
        run(1);  chk("s3_done", align_done, 1'b1); chk("s3_fail", align_fail, 1'b1);

        // Corrupt word at the 10th CHECK match on lane 0.
        set_all(PAT); lane_data[0] = 8'hC5;
        cyc(1'b1, 1'b1, 1'b1);
        run(12);
        lane_data[0] = 8'h00; run(1);
        lane_data[0] = 8'hC5;
        run(22); chk("s4_prelock", locked[0], 1'b0);
        run(1);  chk("s4_lock", locked[0], 1'b1);

        // in_valid toggling.
        cyc(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 19; i++) begin
            cyc(1'b0, 1'b0, 1'b1);
            if (i == 0) chk("s5_gap_valid", out_valid, 1'b0);
            cyc(1'b0, 1'b1, 1'b1);
            if (i == 17) chk("s5_prelock", locked[0], 1'b0);
        end
        chk("s5_lock", locked[0], 1'b1);

        // Reset mid-CHECK; lanes must stay idle afterwards.
        cyc(1'b1, 1'b1, 1'b1);
        run(8);
        cyc(1'b0, 1'b1, 1'b0);
        chk("s6_locked", locked, 16'h0000);
        chk("s6_out_valid", out_valid, 1'b0);
        chk("s6_data", data_out, 128'h0);
        chk("s6_done", align_done, 1'b0);
        chk("s6_fail", align_fail, 1'b0);
        run(30);
        chk("s6_idle_locked", locked, 16'h0000);
        chk("s6_idle_done", align_done, 1'b0);

`ifdef AD_SERDES_IN_ALIGN_ERRCNT_EN
        cyc(1'b1, 1'b1, 1'b1);
        run(19); chk("s7_lock", locked[0], 1'b1);
        check_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lane_data[0] = 8'hC4; run(1);
            lane_data[0] = 8'hC5; run(1);
        end
        check_en = 1'b0;
        chk("s7_err_cnt", err_cnt[15:0], 16'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ad_serdes_in_align.md
Name: ad_serdes_in_align

Overview:
- Fabric-side word aligner for the receive direction of the LVDS SERDES link; the receive counterpart of the serializing output path.
- Takes per-lane raw SERDES_FACTOR-bit parallel words from the input deserializers, all in the divided clock domain.
- Finds the bit offset at which each lane's training pattern appears, using a fabric barrel shift, then outputs word-aligned data and per-lane lock status.

Parameters:
- SERDES_FACTOR, 8, bits per word per lane.
- DATA_WIDTH, 16, number of lanes.
- TRAIN_PATTERN, 8'hB8, expected aligned word; width SERDES_FACTOR; all rotations must be distinct.
- MATCH_COUNT, 16, consecutive matching valid words required to lock.

Ports:
- clk  input  1  single clock, divided word clock.
- rst_n  input  1  synchronous active-low reset.
- align_req  input  1  one-cycle pulse; restarts alignment on all lanes.
- in_valid  input  1  data_in word qualifier.
- data_in  input  DATA_WIDTH*SERDES_FACTOR  lane l at [l*SF +: SF]; bit 0 received first.
- out_valid  output  1  data_out qualifier.
- data_out  output  DATA_WIDTH*SERDES_FACTOR  aligned words, same lane packing.
- locked  output  DATA_WIDTH  per-lane LOCKED state.
- align_done  output  1  every lane is in LOCKED or FAIL.
- align_fail  output  1  at least one lane is in FAIL.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low. Every register clears when rst_n=0 at a clk edge.
- Reset values:
  - out_valid=0, data_out=0, locked=0, align_done=0, align_fail=0.
  - Each lane: offset=0, state IDLE, prev=0, counters=0.
- Per lane, prev is captured from the lane's data_in on each in_valid.
- Selected word at offset k (0..SF-1) is {cur[k-1:0], prev[SF-1:k]}. Offset 0 selects prev.
- Output latency: 1 clk. out_valid = in_valid delayed one cycle; data_out = registered selected word.
- State and counter updates happen only on in_valid=1. With in_valid=0, state, offset and counters hold.
- Lane FSM:
  - IDLE: wait for align_req.
  - align_req, from any state: offset=0, match_cnt=0, slip_cnt=0, go to SEARCH. A word arriving in the same cycle is not compared, because align_req has priority.
  - SEARCH, selected word == TRAIN_PATTERN: match_cnt=1, go to CHECK.
  - SEARCH, mismatch: offset wraps SF-1 -> 0; slip_cnt+1.
  - CHECK, match: match_cnt+1. When match_cnt reaches MATCH_COUNT, go to LOCKED.
  - CHECK, mismatch: match_cnt=0, offset+1 (wrap), slip_cnt+1, go to SEARCH.
  - Any slip that makes slip_cnt reach 2*SERDES_FACTOR: go to FAIL, offset held.
  - LOCKED and FAIL hold until the next align_req or reset.
- A new offset applies to the very next valid word; there is no blanking.
- align_done and align_fail are registered reductions over the lane states. Both are 0 while any lane is in IDLE, SEARCH or CHECK.
- Counter widths: match_cnt is $clog2(MATCH_COUNT+1) bits; slip_cnt is $clog2(2*SF+1) bits. Neither counter overflows.
- Reset asserted mid-alignment: the aligner stays in IDLE after release and does not restart on its own.

Optional Feature:
- Macro: AD_SERDES_IN_ALIGN_ERRCNT_EN.
- Defined:
  - Adds input check_en (1) and output err_cnt (DATA_WIDTH*16).
  - Each lane counts, with 16-bit saturation at 16'hFFFF, valid words that mismatch TRAIN_PATTERN while LOCKED and check_en=1.
  - Cleared on reset and on align_req.
- Undefined: these ports and the logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package ad_serdes_pkg:
  - Lane state enum: IDLE, SEARCH, CHECK, LOCKED, FAIL.
  - Function for the counter width calculation.
  - Default TRAIN_PATTERN constant.
- One sub-module, ad_serdes_in_lane_align:
  - Owns the per-lane prev register, barrel select, FSM, counters and optional err_cnt.
  - Instantiated DATA_WIDTH times by a generate loop.
- Top level holds the out_valid register and the align_done/align_fail reductions.

Test Plan:
- Lane 0 stream 0xB8 rotated 3 bits, continuous in_valid, align_req pulse -> offset=3, locked[0] after 3+16 valid words, data_out lane0 = 8'hB8 on every valid thereafter.
- Lanes 0..7 rotated by 0..7, other lanes offset 0 -> each lane's offset equals its rotation; align_done=1, align_fail=0 once the last lane locks.
- Lane 5 fed a constant 8'h00 -> lane 5 in FAIL after 16 valid words, align_fail=1 and align_done=1 once the others lock; locked[5]=0.
- Lane 0 aligned at offset 3, one corrupt word at CHECK match 10 -> offset goes to 4, wraps back to 3 after 7 further slips (total 11 < 16), then locks.
- in_valid toggling 1/0 each cycle with the first scenario's stream -> same lock result after 19 valid words; nothing advances on in_valid=0 cycles.
- rst_n=0 for one cycle while in CHECK -> all outputs 0 next cycle, lane stays in IDLE until align_req. With ERRCNT_EN: after lock, check_en=1 and 3 corrupt words -> err_cnt lane = 3.
